// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the D-stage hazard logic: code widths, the
// "source not read" Tuse marker and the forwarding-select encoding.
package cpu_hazard_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned T_W    = 2;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_src_check.sv
// Per-source hazard check: finds the newest shadow stage writing this source
// register and derives the stall request and D-stage forwarding select.
module hazard_src_check #(
    parameter int unsigned ADDR_W = cpu_hazard_pkg::ADDR_W,
    parameter int unsigned T_W    = cpu_hazard_pkg::T_W
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [T_W-1:0]    tuse,
    input  logic [ADDR_W-1:0] a3_e,
    input  logic [T_W-1:0]    tnew_e,
    input  logic [ADDR_W-1:0] a3_m,
    input  logic [T_W-1:0]    tnew_m,
    input  logic [ADDR_W-1:0] a3_w,
    input  logic [T_W-1:0]    tnew_w,
    output logic              stall_s,
    output logic [1:0]        fwd_s
);

    logic                     live;
    logic                     hit_e;
    logic                     hit_m;
    logic                     hit_w;
    logic                     hit;
    logic [T_W-1:0]           sel_tnew;
    cpu_hazard_pkg::fwd_sel_e sel_code;

    always_comb begin
        live     = (src != '0) && (tuse != T_W'(cpu_hazard_pkg::TUSE_NONE));
        hit_e    = live && (a3_e == src);
        hit_m    = live && (a3_m == src);
        hit_w    = live && (a3_w == src);
        hit      = hit_e || hit_m || hit_w;
        sel_tnew = '0;
        sel_code = cpu_hazard_pkg::FWD_RF;

        // Newest producer shadows any older one, even if the older is ready.
        if (hit_e) begin
            sel_tnew = tnew_e;
            sel_code = cpu_hazard_pkg::FWD_E;
        end else if (hit_m) begin
            sel_tnew = tnew_m;
            sel_code = cpu_hazard_pkg::FWD_M;
        end else if (hit_w) begin
            sel_tnew = tnew_w;
            sel_code = cpu_hazard_pkg::FWD_W;
        end

        stall_s = hit && (sel_tnew > tuse);
        fwd_s   = (hit && (sel_tnew == '0)) ? sel_code : cpu_hazard_pkg::FWD_RF;
    end

endmodule

// File: rtl/hazard_tracker.sv
// Shadow E/M/W pipeline of {a3, tnew} driving the global stall, D-stage
// forwarding selects and a saturating stall-cycle counter.
module hazard_tracker #(
    parameter int unsigned ADDR_W = cpu_hazard_pkg::ADDR_W,
    parameter int unsigned T_W    = cpu_hazard_pkg::T_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [ADDR_W-1:0] rs_D,
    input  logic [ADDR_W-1:0] rt_D,
    input  logic [T_W-1:0]    tuse_rs_D,
    input  logic [T_W-1:0]    tuse_rt_D,
    input  logic [ADDR_W-1:0] a3_D,
    input  logic [T_W-1:0]    tnew_D,
    output logic              stall,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [ADDR_W-1:0] e_a3_q, e_a3_d;
    logic [ADDR_W-1:0] m_a3_q, m_a3_d;
    logic [ADDR_W-1:0] w_a3_q, w_a3_d;
    logic [T_W-1:0]    e_tnew_q, e_tnew_d;
    logic [T_W-1:0]    m_tnew_q, m_tnew_d;
    logic [T_W-1:0]    w_tnew_q, w_tnew_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_rs;
    logic              stall_rt;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_W'(1);
    endfunction

    hazard_src_check #(.ADDR_W(ADDR_W), .T_W(T_W)) u_chk_rs (
        .src     (rs_D),
        .tuse    (tuse_rs_D),
        .a3_e    (e_a3_q),
        .tnew_e  (e_tnew_q),
        .a3_m    (m_a3_q),
        .tnew_m  (m_tnew_q),
        .a3_w    (w_a3_q),
        .tnew_w  (w_tnew_q),
        .stall_s (stall_rs),
        .fwd_s   (fwd_rs_D)
    );

    hazard_src_check #(.ADDR_W(ADDR_W), .T_W(T_W)) u_chk_rt (
        .src     (rt_D),
        .tuse    (tuse_rt_D),
        .a3_e    (e_a3_q),
        .tnew_e  (e_tnew_q),
        .a3_m    (m_a3_q),
        .tnew_m  (m_tnew_q),
        .a3_w    (w_a3_q),
        .tnew_w  (w_tnew_q),
        .stall_s (stall_rt),
        .fwd_s   (fwd_rt_D)
    );

    assign stall     = stall_rs | stall_rt;
    assign stall_cnt = cnt_q;

    always_comb begin
        e_a3_d   = e_a3_q;
        e_tnew_d = e_tnew_q;
        m_a3_d   = m_a3_q;
        m_tnew_d = m_tnew_q;
        w_a3_d   = w_a3_q;
        w_tnew_d = w_tnew_q;
        cnt_d    = cnt_q;

        // A stall arriving during hold waits; the bubble goes in on release.
        if (!hold) begin
            w_a3_d   = m_a3_q;
            w_tnew_d = sat_dec(m_tnew_q);
            m_a3_d   = e_a3_q;
            m_tnew_d = sat_dec(e_tnew_q);
            e_a3_d   = stall ? '0 : a3_D;
            e_tnew_d = stall ? '0 : tnew_D;
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
            w_tnew_q <= '0;
            cnt_q    <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            w_tnew_q <= w_tnew_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: expected outputs are queued as each
// step is driven and compared against the DUT mid-cycle.
module tb_hazard_tracker;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          hold;
    logic [4:0]    rs_D, rt_D, a3_D;
    logic [1:0]    tuse_rs_D, tuse_rt_D, tnew_D;
    logic          stall;
    logic [1:0]    fwd_rs_D, fwd_rt_D;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string         tag;
        logic          st;
        logic [1:0]    frs;
        logic [1:0]    frt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_cnt;

    hazard_tracker #(.ADDR_W(5), .T_W(2), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .a3_D      (a3_D),
        .tnew_D    (tnew_D),
        .stall     (stall),
        .fwd_rs_D  (fwd_rs_D),
        .fwd_rt_D  (fwd_rt_D),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference counter: advances when the bench itself expects a stall.
    task automatic tick(input bit stalling);
        if (!reset) exp_cnt = '0;
        else if (stalling && !hold && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] a3, input logic [1:0] tn);
        rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
        a3_D = a3; tnew_D = tn;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 3; i++) tick(1'b0);
    endtask

    task automatic check();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (stall === e.st) else begin
                bad++;
                $error("FAIL %s.stall observed=%0b expected=%0b", e.tag, stall, e.st);
            end
            total++;
            assert (fwd_rs_D === e.frs) else begin
                bad++;
                $error("FAIL %s.fwd_rs observed=%0d expected=%0d", e.tag, fwd_rs_D, e.frs);
            end
            total++;
            assert (fwd_rt_D === e.frt) else begin
                bad++;
                $error("FAIL %s.fwd_rt observed=%0d expected=%0d", e.tag, fwd_rt_D, e.frt);
            end
            total++;
            assert (stall_cnt === e.cnt) else begin
                bad++;
                $error("FAIL %s.cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
            end
        end
    endtask

    task automatic step(input string tag, input logic st,
                        input logic [1:0] frs, input logic [1:0] frt);
        exp_t e;
        e.tag = tag; e.st = st; e.frs = frs; e.frt = frt; e.cnt = exp_cnt;
        sb.push_back(e);
        check();
    endtask

    initial begin
        reset = 1'b0;
        hold = 1'b0;
        exp_cnt = '0;
        nop();
        tick(1'b0);
        tick(1'b0);
        step("reset", 1'b0, 2'd0, 2'd0);
        reset = 1'b1;

        // lw $1 -> addu $3,$1,$2
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2);
        step("t1_lw", 1'b0, 2'd0, 2'd0);
        tick(1'b0);
        drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1);
        step("t1_stall", 1'b1, 2'd0, 2'd0);
        tick(1'b1);
        step("t1_release", 1'b0, 2'd0, 2'd0);
        flush();

        // lw $1 -> beq $1,$2
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2);
        tick(1'b0);
        drive(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0);
        step("t2_stall0", 1'b1, 2'd0, 2'd0);
        tick(1'b1);
        step("t2_stall1", 1'b1, 2'd0, 2'd0);
        tick(1'b1);
        step("t2_fwd_w", 1'b0, 2'd3, 2'd0);
        flush();

        // addu $1 -> beq $1,$0
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1);
        tick(1'b0);
        drive(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        step("t3_stall", 1'b1, 2'd0, 2'd0);
        tick(1'b1);
        step("t3_fwd_m", 1'b0, 2'd2, 2'd0);
        flush();

        // jal -> jr $31
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0);
        tick(1'b0);
        drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        step("t4_fwd_e", 1'b0, 2'd1, 2'd0);
        flush();

        // ori $0 -> beq $0,$0
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1);
        step("t5_ori", 1'b0, 2'd0, 2'd0);
        tick(1'b0);
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        step("t5_beq_e", 1'b0, 2'd0, 2'd0);
        tick(1'b0);
        step("t5_beq_m", 1'b0, 2'd0, 2'd0);
        flush();

        // rt path through M then W, then both sources on one register
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1);
        tick(1'b0);
        drive(5'd0, 5'd5, 2'd3, 2'd1, 5'd0, 2'd0);
        step("rt_pending", 1'b0, 2'd0, 2'd0);
        tick(1'b0);
        step("rt_fwd_m", 1'b0, 2'd0, 2'd2);
        tick(1'b0);
        step("rt_fwd_w", 1'b0, 2'd0, 2'd3);
        drive(5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0);
        step("both_fwd_w", 1'b0, 2'd3, 2'd3);
        flush();

        // Tuse=3 masks an otherwise stalling match
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2);
        tick(1'b0);
        drive(5'd7, 5'd7, 2'd3, 2'd3, 5'd0, 2'd0);
        step("tuse_none", 1'b0, 2'd0, 2'd0);
        flush();

        // E beats a ready M; hold freezes; reset wins mid-stall
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1);
        tick(1'b0);
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2);
        step("p_lw_d", 1'b0, 2'd0, 2'd0);
        tick(1'b0);
        drive(5'd1, 5'd0, 2'd1, 2'd3, 5'd4, 2'd1);
        step("p_e_wins", 1'b1, 2'd0, 2'd0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            step("p_hold", 1'b1, 2'd0, 2'd0);
        end
        hold = 1'b0;
        reset = 1'b0;
        tick(1'b1);
        step("p_reset", 1'b0, 2'd0, 2'd0);
        reset = 1'b1;

        // lw tnew=3 -> beq: three stall cycles each, counter saturates
        for (int r = 0; r < 3; r++) begin
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd3);
            tick(1'b0);
            drive(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
            for (int c = 0; c < 3; c++) begin
                step("sat_stall", 1'b1, 2'd0, 2'd0);
                tick(1'b1);
            end
            step("sat_release", 1'b0, 2'd0, 2'd0);
            nop();
            tick(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
